// File: rtl/gol_vga_pkg.sv
// Shared types and constants for the GoL -> VGA text-mode VRAM master.
// Holds the half-word layout, the palette location and the default palette.
package gol_vga_pkg;

  typedef struct packed {
    logic       iv;
    logic [6:0] code;
    logic [3:0] fg;
    logic [3:0] bg;
  } vram_hword_t;

  typedef enum logic [1:0] {IDLE, PAL, CELL} fsm_state_t;

  localparam logic [13:0] PALETTE_BASE = 14'h2000;
  localparam int unsigned PAL_ENTRIES  = 16;

  // CGA-style 16-colour palette, 12-bit RGB stored in bits [12:1]
  localparam logic [15:0] DEF_PALETTE [PAL_ENTRIES] = '{
    16'h0000, 16'h0014, 16'h0140, 16'h0154,
    16'h1400, 16'h1414, 16'h14A0, 16'h1554,
    16'h0AAA, 16'h0ABE, 16'h0BEA, 16'h0BFE,
    16'h1EAA, 16'h1EBE, 16'h1FEA, 16'h1FFE
  };

  function automatic logic [3:0] hword_be(input logic hi);
    return hi ? 4'b1100 : 4'b0011;
  endfunction

  function automatic logic [31:0] hword_lane(input logic hi, input logic [15:0] hw);
    return hi ? {hw, 16'h0000} : {16'h0000, hw};
  endfunction

endpackage

// File: rtl/gol_vram_master_if.sv
// Avalon-MM write-only bus between the VRAM master and the VGA text-mode slave.
interface gol_vram_master_if;
  logic [13:0] AVM_ADDR;
  logic        AVM_WRITE;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;
  logic        AVM_WAITREQUEST;

  modport master (
    output AVM_ADDR, AVM_WRITE, AVM_BYTE_EN, AVM_WRITEDATA,
    input  AVM_WAITREQUEST
  );

  modport slave (
    input  AVM_ADDR, AVM_WRITE, AVM_BYTE_EN, AVM_WRITEDATA,
    output AVM_WAITREQUEST
  );
endinterface

// File: rtl/gol_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and show-ahead read data.
module gol_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/gol_vram_master.sv
// Avalon-MM write master: queues GoL cell updates as VRAM half-word writes
// and loads the default 16-entry palette on request.
module gol_vram_master
  import gol_vga_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [6:0]  ALIVE_CODE = 7'h02,
  parameter logic [6:0]  DEAD_CODE  = 7'h00,
  parameter logic [3:0]  FG_IDX     = 4'hF,
  parameter logic [3:0]  BG_IDX     = 4'h0
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               cell_valid,
  output logic               cell_ready,
  input  logic [13:0]        cell_idx,
  input  logic               cell_alive,
  input  logic               start_init,
  output logic               busy,
  gol_vram_master_if.master  avm
);

  localparam int unsigned ENTRY_W = 15;

  fsm_state_t         state;
  logic               init_pend;
  logic [3:0]         pal_k;
  logic [3:0]         pal_sel;
  logic               push, pop, fifo_full, fifo_empty, wr_done;
  logic [ENTRY_W-1:0] fifo_rd;
  logic [13:0]        q_idx;
  vram_hword_t        cell_hw;
  logic               ld_cell;
  logic [13:0]        ld_addr;
  logic [3:0]         ld_be;
  logic [31:0]        ld_data;

  gol_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (push),
    .wr_data ({cell_idx, cell_alive}),
    .full    (fifo_full),
    .pop     (pop),
    .rd_data (fifo_rd),
    .empty   (fifo_empty)
  );

  assign cell_ready = ~fifo_full;
  assign push       = cell_valid & ~fifo_full;
  assign wr_done    = avm.AVM_WRITE & ~avm.AVM_WAITREQUEST;
  assign busy       = init_pend | (state != IDLE) | ~fifo_empty;

  // The next beat is either the FIFO head or palette entry pal_sel; the FSM
  // only decides when to load it.
  always_comb begin
    q_idx        = fifo_rd[ENTRY_W-1:1];
    cell_hw      = '0;
    cell_hw.code = fifo_rd[0] ? ALIVE_CODE : DEAD_CODE;
    cell_hw.fg   = FG_IDX;
    cell_hw.bg   = BG_IDX;
    pal_sel      = (state == PAL) ? pal_k + 4'd1 : '0;
    pop          = 1'b0;
    if (!fifo_empty && !init_pend)
      pop = (state == IDLE) || ((state == CELL) && wr_done);
    ld_cell = (state == CELL) || ((state == IDLE) && !init_pend);
    if (ld_cell) begin
      ld_addr = {1'b0, q_idx[13:1]};
      ld_be   = hword_be(q_idx[0]);
      ld_data = hword_lane(q_idx[0], cell_hw);
    end else begin
      ld_addr = PALETTE_BASE | 14'(pal_sel[3:1]);
      ld_be   = hword_be(pal_sel[0]);
      ld_data = hword_lane(pal_sel[0], DEF_PALETTE[pal_sel]);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state             <= IDLE;
      init_pend         <= 1'b0;
      pal_k             <= '0;
      avm.AVM_WRITE     <= 1'b0;
      avm.AVM_ADDR      <= '0;
      avm.AVM_BYTE_EN   <= '0;
      avm.AVM_WRITEDATA <= '0;
    end else begin
      if (start_init && !init_pend && (state != PAL))
        init_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (init_pend) begin
            state             <= PAL;
            init_pend         <= 1'b0;
            pal_k             <= '0;
            avm.AVM_WRITE     <= 1'b1;
            avm.AVM_ADDR      <= ld_addr;
            avm.AVM_BYTE_EN   <= ld_be;
            avm.AVM_WRITEDATA <= ld_data;
          end else if (pop) begin
            state             <= CELL;
            avm.AVM_WRITE     <= 1'b1;
            avm.AVM_ADDR      <= ld_addr;
            avm.AVM_BYTE_EN   <= ld_be;
            avm.AVM_WRITEDATA <= ld_data;
          end
        end
        PAL: begin
          if (wr_done) begin
            if (pal_k == 4'd15) begin
              avm.AVM_WRITE <= 1'b0;
              state         <= IDLE;
            end else begin
              pal_k             <= pal_sel;
              avm.AVM_ADDR      <= ld_addr;
              avm.AVM_BYTE_EN   <= ld_be;
              avm.AVM_WRITEDATA <= ld_data;
            end
          end
        end
        CELL: begin
          if (wr_done) begin
            if (pop) begin
              avm.AVM_ADDR      <= ld_addr;
              avm.AVM_BYTE_EN   <= ld_be;
              avm.AVM_WRITEDATA <= ld_data;
            end else begin
              avm.AVM_WRITE <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_vram_master.sv
// Self-checking bench for gol_vram_master: completed Avalon writes are logged
// and compared against an arithmetic model of the cell and palette formats.
module tb_gol_vram_master;

  typedef struct packed {
    logic [13:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        cell_valid = 1'b0;
  logic        cell_ready;
  logic [13:0] cell_idx = '0;
  logic        cell_alive = 1'b0;
  logic        start_init = 1'b0;
  logic        busy;

  gol_vram_master_if avm();

  gol_vram_master #(
    .FIFO_DEPTH (4),
    .ALIVE_CODE (7'h02),
    .DEAD_CODE  (7'h00),
    .FG_IDX     (4'hF),
    .BG_IDX     (4'h0)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .cell_valid (cell_valid),
    .cell_ready (cell_ready),
    .cell_idx   (cell_idx),
    .cell_alive (cell_alive),
    .start_init (start_init),
    .busy       (busy),
    .avm        (avm)
  );

  always #10 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  wr_t got_q[$];
  wr_t exp_q[$];

  // Default palette as plain 12-bit RGB (CGA colours)
  logic [11:0] pal_rgb [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  // Inputs change only at posedge+1, so a write seen here completes at the next edge
  always @(negedge CLK) begin
    if (RESET_N && avm.AVM_WRITE && !avm.AVM_WAITREQUEST)
      got_q.push_back({avm.AVM_ADDR, avm.AVM_BYTE_EN, avm.AVM_WRITEDATA});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic wr_t exp_cell(input int unsigned idx, input bit alive);
    wr_t w;
    int unsigned hw;
    hw = (alive ? 32'd2 : 32'd0) * 256 + 32'd15 * 16;
    w.addr = 14'(idx / 2);
    w.be   = (idx % 2 == 1) ? 4'b1100 : 4'b0011;
    w.data = (idx % 2 == 1) ? hw * 65536 : hw;
    return w;
  endfunction

  function automatic wr_t exp_pal(input int unsigned k);
    wr_t w;
    int unsigned hw;
    hw = 32'(pal_rgb[k]) * 2;
    w.addr = 14'(32'h2000 + k / 2);
    w.be   = (k % 2 == 1) ? 4'b1100 : 4'b0011;
    w.data = (k % 2 == 1) ? hw * 65536 : hw;
    return w;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic push_cell(input logic [13:0] idx, input bit alive);
    bit r;
    r = 1'b0;
    cell_idx = idx;
    cell_alive = alive;
    cell_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      r = cell_ready;
      tick();
      if (r) break;
    end
    cell_valid = 1'b0;
    vectors++;
    if (r !== 1'b1) begin
      miscompares++;
      $display("FAIL push_accept idx=%0d: cell_ready got %b, required 1 within 100 cycles", idx, r);
    end else begin
      exp_q.push_back(exp_cell(idx, alive));
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    avm.AVM_WAITREQUEST = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({avm.AVM_WRITE, avm.AVM_ADDR, avm.AVM_BYTE_EN, avm.AVM_WRITEDATA} !== 51'd0) begin
      miscompares++;
      $display("FAIL reset_avm: write=%b addr=%h be=%b data=%h, required all zero",
               avm.AVM_WRITE, avm.AVM_ADDR, avm.AVM_BYTE_EN, avm.AVM_WRITEDATA);
    end
    vectors++;
    if ({cell_ready, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_flags: ready=%b busy=%b, required ready=1 busy=0", cell_ready, busy);
    end
    RESET_N = 1'b1;
    repeat (5) tick();
    vectors++;
    if (got_q.size() !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: writes=%0d busy=%b, required 0 writes busy=0", got_q.size(), busy);
    end
  endtask

  task automatic test_palette();
    bit to;
    got_q.delete();
    exp_q.delete();
    avm.AVM_WAITREQUEST = 1'b0;
    start_init = 1'b1;
    tick();
    start_init = 1'b0;
    for (int k = 0; k < 16; k++) exp_q.push_back(exp_pal(k));
    wait_idle(200, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL palette_idle: busy got 1, required 0 within 200 cycles");
    end
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL palette_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL palette[%0d]: got addr=%h be=%b data=%h, required addr=%h be=%b data=%h", i,
                 got_q[i].addr, got_q[i].be, got_q[i].data, exp_q[i].addr, exp_q[i].be, exp_q[i].data);
      end
    end
  endtask

  task automatic test_cell_format();
    bit to;
    wr_t spec5;
    wr_t spec4;
    spec5 = '{addr: 14'h0002, be: 4'b1100, data: 32'h02F0_0000};
    spec4 = '{addr: 14'h0002, be: 4'b0011, data: 32'h0000_00F0};
    got_q.delete();
    exp_q.delete();
    avm.AVM_WAITREQUEST = 1'b0;
    push_cell(14'd5, 1'b1);
    push_cell(14'd4, 1'b0);
    wait_idle(100, to);
    vectors++;
    if (to || got_q.size() !== 2) begin
      miscompares++;
      $display("FAIL cell_count: got %0d writes (timeout=%b), required 2", got_q.size(), to);
    end else begin
      vectors++;
      if (got_q[0] !== spec5) begin
        miscompares++;
        $display("FAIL cell5_alive: got addr=%h be=%b data=%h, required 0002/1100/02f00000",
                 got_q[0].addr, got_q[0].be, got_q[0].data);
      end
      vectors++;
      if (got_q[1] !== spec4) begin
        miscompares++;
        $display("FAIL cell4_dead: got addr=%h be=%b data=%h, required 0002/0011/000000f0",
                 got_q[1].addr, got_q[1].be, got_q[1].data);
      end
      vectors++;
      if (got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
        miscompares++;
        $display("FAIL cell_model: got %h %h, required %h %h", got_q[0], got_q[1], exp_q[0], exp_q[1]);
      end
    end
  endtask

  task automatic test_stall();
    bit to;
    bit r;
    int accepted;
    wr_t snap;
    wr_t now;
    logic [13:0] idx;
    bit alive;
    got_q.delete();
    exp_q.delete();
    accepted = 0;
    avm.AVM_WAITREQUEST = 1'b1;
    idx = 14'($urandom_range(0, 16383));
    alive = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) begin
      cell_idx = idx;
      cell_alive = alive;
      cell_valid = 1'b1;
      r = cell_ready;
      tick();
      if (r) begin
        accepted++;
        exp_q.push_back(exp_cell(idx, alive));
        idx = 14'($urandom_range(0, 16383));
        alive = 1'($urandom_range(0, 1));
      end
    end
    cell_valid = 1'b0;
    // One entry sits in the output registers, the rest fill the FIFO
    vectors++;
    if (accepted !== 5 || cell_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_fill: accepted %0d ready=%b, required 5 accepted ready=0", accepted, cell_ready);
    end
    snap = {avm.AVM_ADDR, avm.AVM_BYTE_EN, avm.AVM_WRITEDATA};
    vectors++;
    if (avm.AVM_WRITE !== 1'b1 || snap !== exp_q[0]) begin
      miscompares++;
      $display("FAIL stall_head: write=%b beat=%h, required write=1 beat=%h", avm.AVM_WRITE, snap, exp_q[0]);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      now = {avm.AVM_ADDR, avm.AVM_BYTE_EN, avm.AVM_WRITEDATA};
      vectors++;
      if (avm.AVM_WRITE !== 1'b1 || now !== snap) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: write=%b beat=%h, required write=1 beat=%h", i, avm.AVM_WRITE, now, snap);
      end
    end
    avm.AVM_WAITREQUEST = 1'b0;
    wait_idle(100, to);
    vectors++;
    if (to || got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL stall_count: got %0d writes (timeout=%b), required %0d", got_q.size(), to, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL stall_order[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_init_during_cells();
    bit to;
    wr_t cells[$];
    got_q.delete();
    exp_q.delete();
    avm.AVM_WAITREQUEST = 1'b1;
    for (int i = 0; i < 5; i++)
      push_cell(14'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)));
    cells = exp_q;
    exp_q.delete();
    if (cells.size() > 0) exp_q.push_back(cells[0]);
    for (int k = 0; k < 16; k++) exp_q.push_back(exp_pal(k));
    for (int i = 1; i < cells.size(); i++) exp_q.push_back(cells[i]);
    start_init = 1'b1;
    tick();
    start_init = 1'b0;
    avm.AVM_WAITREQUEST = 1'b0;
    wait_idle(200, to);
    vectors++;
    if (to || got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL mix_count: got %0d writes (timeout=%b), required %0d", got_q.size(), to, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL mix_order[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_palette();
    bit to;
    bit found;
    got_q.delete();
    exp_q.delete();
    found = 1'b0;
    avm.AVM_WAITREQUEST = 1'b0;
    start_init = 1'b1;
    tick();
    start_init = 1'b0;
    push_cell(14'($urandom_range(0, 16383)), 1'b1);
    push_cell(14'($urandom_range(0, 16383)), 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (avm.AVM_WRITE && avm.AVM_ADDR == 14'h2003 && avm.AVM_BYTE_EN == 4'b1100) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL midpal_reach: palette write 7 got not seen, required within 100 cycles");
    end
    RESET_N = 1'b0;
    #1;
    vectors++;
    if ({avm.AVM_WRITE, busy, cell_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL midpal_reset: write=%b busy=%b ready=%b, required write=0 busy=0 ready=1",
               avm.AVM_WRITE, busy, cell_ready);
    end
    tick();
    tick();
    got_q.delete();
    exp_q.delete();
    RESET_N = 1'b1;
    repeat (5) tick();
    vectors++;
    if (got_q.size() !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midpal_flushed: writes=%0d busy=%b, required 0 writes busy=0", got_q.size(), busy);
    end
    start_init = 1'b1;
    tick();
    start_init = 1'b0;
    for (int k = 0; k < 16; k++) exp_q.push_back(exp_pal(k));
    wait_idle(200, to);
    vectors++;
    if (to || got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL midpal_restart_count: got %0d writes (timeout=%b), required %0d", got_q.size(), to, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL midpal_restart[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_stream();
    bit to;
    bit v;
    bit r;
    got_q.delete();
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      avm.AVM_WAITREQUEST = ($urandom_range(0, 1) == 0);
      v = 1'($urandom_range(0, 1));
      cell_valid = v;
      cell_idx = 14'($urandom_range(0, 16383));
      cell_alive = 1'($urandom_range(0, 1));
      r = cell_ready;
      if (v && r) exp_q.push_back(exp_cell(cell_idx, cell_alive));
      tick();
    end
    cell_valid = 1'b0;
    avm.AVM_WAITREQUEST = 1'b0;
    wait_idle(100, to);
    vectors++;
    if (to || got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL random_count: got %0d writes (timeout=%b), required %0d", got_q.size(), to, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_palette();
    test_cell_format();
    test_stall();
    test_init_during_cells();
    test_reset_mid_palette();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
